// File: rtl/snake_pkg.sv
// Shared snake types: headings, tilt FSM states and acl_data field slices.
// Z-axis face-down guard is enabled with `define FLIP_GUARD_EN.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP    = 2'b00,
        DIR_RIGHT = 2'b01,
        DIR_DOWN  = 2'b10,
        DIR_LEFT  = 2'b11
    } dir_e;

    localparam logic DIR_NONE = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_QUALIFY = 2'b01,
        ST_ARMED   = 2'b10
    } tilt_state_e;

    localparam int ACL_W    = 15;
    localparam int AXIS_W   = 5;
    localparam int ACL_X_HI = 14;
    localparam int ACL_X_LO = 10;
    localparam int ACL_Y_HI = 9;
    localparam int ACL_Y_LO = 5;
    localparam int ACL_Z_HI = 4;
    localparam int ACL_Z_LO = 0;

    function automatic dir_e opposite(input dir_e d);
        return dir_e'(d ^ 2'b10);
    endfunction

endpackage

// File: rtl/tilt_classifier.sv
// Combinational tilt classifier: picks the dominant axis, applies
// threshold/hysteresis and maps the sign to a heading (FLIP_GUARD_EN aware).
module tilt_classifier
    import snake_pkg::*;
#(
    parameter int TILT_THRESH = 4,
    parameter int HYST        = 1
) (
    input  logic [AXIS_W-1:0] x_i,
    input  logic [AXIS_W-1:0] y_i,
    input  logic              flip_i,
    input  dir_e              cur_dir_i,
    input  logic              hyst_en_i,
    input  dir_e              track_dir_i,
    output dir_e              cand_o,
    output logic              none_o
);

    localparam logic [5:0] THR_HI = 6'(TILT_THRESH);
    localparam logic [5:0] THR_LO = 6'(TILT_THRESH - HYST);

    function automatic logic [5:0] abs5(input logic [AXIS_W-1:0] v);
        logic [5:0] e;
        e = {v[AXIS_W-1], v};
        return v[AXIS_W-1] ? (~e + 6'd1) : e;
    endfunction

    logic [5:0] ax;
    logic [5:0] ay;
    logic [5:0] mag;
    logic [5:0] thr;
    logic       use_x;

    always_comb begin
        ax     = abs5(x_i);
        ay     = abs5(y_i);
        // Ties favour the axis we are already travelling on.
        use_x  = (ax > ay) || ((ax == ay) && cur_dir_i[0]);
        mag    = use_x ? ax : ay;
        cand_o = DIR_RIGHT;
        if (use_x) begin
            cand_o = x_i[AXIS_W-1] ? DIR_LEFT : DIR_RIGHT;
        end else begin
            cand_o = y_i[AXIS_W-1] ? DIR_DOWN : DIR_UP;
        end
        thr    = (hyst_en_i && (cand_o == track_dir_i)) ? THR_LO : THR_HI;
        none_o = (mag < thr) || (mag == 6'd0) || flip_i;
    end

endmodule

// File: rtl/tilt_direction.sv
// Accelerometer tilt to debounced, non-reversing snake heading.
// Define FLIP_GUARD_EN to suppress steering while the board is face-down.
module tilt_direction
    import snake_pkg::*;
#(
    parameter int TILT_THRESH = 4,
    parameter int HYST        = 1,
    parameter int HOLD_CYCLES = 2000000,
    parameter int CNT_W       = $clog2(HOLD_CYCLES + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ACL_W-1:0] acl_data,
    input  logic             game_tick,
    output logic [1:0]       dir_out,
    output logic             dir_change,
    output logic             armed
);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

    logic [ACL_W-1:0] sync1_q;
    logic [ACL_W-1:0] sync2_q;
    logic [ACL_W-1:0] samp_q;

    tilt_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    dir_e             cand_q, cand_d;
    dir_e             dir_q, dir_d;
    dir_e             prev_dir_q;
    logic             armed_q, armed_d;
    logic             chg_q;

    dir_e cand;
    logic none;
    logic flip;

`ifdef FLIP_GUARD_EN
    assign flip = samp_q[ACL_Z_HI];
`else
    logic unused_z;
    assign unused_z = ^samp_q[ACL_Z_HI:ACL_Z_LO];
    assign flip     = 1'b0;
`endif

    // A sample is trusted only once both sync stages agree.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            samp_q  <= '0;
        end else begin
            sync1_q <= acl_data;
            sync2_q <= sync1_q;
            if (sync1_q == sync2_q) begin
                samp_q <= sync2_q;
            end
        end
    end

    tilt_classifier #(
        .TILT_THRESH (TILT_THRESH),
        .HYST        (HYST)
    ) u_classifier (
        .x_i         (samp_q[ACL_X_HI:ACL_X_LO]),
        .y_i         (samp_q[ACL_Y_HI:ACL_Y_LO]),
        .flip_i      (flip),
        .cur_dir_i   (dir_q),
        .hyst_en_i   (state_q != ST_IDLE),
        .track_dir_i (cand_q),
        .cand_o      (cand),
        .none_o      (none)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cand_d  = cand_q;
        dir_d   = dir_q;
        armed_d = armed_q;
        unique case (state_q)
            ST_IDLE: begin
                armed_d = 1'b0;
                if (!none && (cand != dir_q)) begin
                    state_d = ST_QUALIFY;
                    cnt_d   = CNT_ONE;
                    cand_d  = cand;
                end
            end
            ST_QUALIFY: begin
                if (none) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cand != cand_q) begin
                    cnt_d  = CNT_ONE;
                    cand_d = cand;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ST_ARMED;
                    cnt_d   = cnt_q + CNT_ONE;
                    armed_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_ARMED: begin
                if (flip) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end else if (game_tick) begin
                    // Reversals and no-op headings are dropped at commit.
                    if ((cand_q != dir_q) &&
                        (cand_q != opposite(dir_q))) begin
                        dir_d = cand_q;
                    end
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    armed_d = 1'b0;
                end else if (!none && (cand != cand_q)) begin
                    state_d = ST_QUALIFY;
                    cnt_d   = CNT_ONE;
                    cand_d  = cand;
                    armed_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                armed_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            cand_q     <= DIR_RIGHT;
            dir_q      <= DIR_RIGHT;
            prev_dir_q <= DIR_RIGHT;
            armed_q    <= 1'b0;
            chg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cand_q     <= cand_d;
            dir_q      <= dir_d;
            prev_dir_q <= dir_q;
            armed_q    <= armed_d;
            chg_q      <= (dir_q != prev_dir_q);
        end
    end

    assign dir_out    = dir_q;
    assign dir_change = chg_q;
    assign armed      = armed_q;

endmodule

// File: tb/tb_tilt_direction.sv
// Directed bench for tilt_direction with HOLD_CYCLES=4.
// Input set at negedge N is first seen at posedge N+1; armed rises 7 edges later.
module tb_tilt_direction;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] acl_data;
    logic        game_tick;
    logic [1:0]  dir_out;
    logic        dir_change;
    logic        armed;

    int vectors     = 0;
    int miscompares = 0;

    localparam logic [14:0] ACL_ZERO = 15'b00000_00000_00000;
    localparam logic [14:0] Y_P8     = 15'b00000_01000_00000;
    localparam logic [14:0] X_M8     = 15'b11000_00000_00000;
    localparam logic [14:0] X_P1     = 15'b00001_00000_00000;
    localparam logic [14:0] Y_P4     = 15'b00000_00100_00000;
    localparam logic [14:0] Y_P3     = 15'b00000_00011_00000;
    localparam logic [14:0] TIE_M16  = 15'b10000_10000_00000;

    always #5 clk = ~clk;

    tilt_direction #(
        .TILT_THRESH (4),
        .HYST        (1),
        .HOLD_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .acl_data   (acl_data),
        .game_tick  (game_tick),
        .dir_out    (dir_out),
        .dir_change (dir_change),
        .armed      (armed)
    );

    task automatic edges(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset;
        rst       = 1'b1;
        game_tick = 1'b0;
        acl_data  = ACL_ZERO;
        edges(2);
        rst = 1'b0;
        edges(1);
    endtask

    task automatic test_reset;
        rst       = 1'b1;
        game_tick = 1'b0;
        acl_data  = ACL_ZERO;
        edges(1);
        vectors++;
        if (dir_out !== 2'b01) begin
            miscompares++;
            $display("FAIL rst_dir: dir_out=%b want 01", dir_out);
        end
        vectors++;
        if (armed !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_armed: armed=%b want 0", armed);
        end
        vectors++;
        if (dir_change !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_chg: dir_change=%b want 0", dir_change);
        end
        rst = 1'b0;
        edges(8);
        vectors++;
        if (dir_out !== 2'b01 || armed !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_quiet: dir=%b armed=%b want 01/0",
                     dir_out, armed);
        end
    endtask

    task automatic test_commit_up;
        do_reset();
        acl_data = Y_P8;
        edges(6);
        vectors++;
        if (armed !== 1'b0) begin
            miscompares++;
            $display("FAIL up_early: armed=%b want 0", armed);
        end
        game_tick = 1'b1;
        edges(1);
        game_tick = 1'b0;
        vectors++;
        if (armed !== 1'b1) begin
            miscompares++;
            $display("FAIL up_armed: armed=%b want 1", armed);
        end
        vectors++;
        if (dir_out !== 2'b01) begin
            miscompares++;
            $display("FAIL tick_same_cycle: dir=%b want 01", dir_out);
        end
        edges(2);
        game_tick = 1'b1;
        edges(1);
        game_tick = 1'b0;
        vectors++;
        if (dir_out !== 2'b00 || armed !== 1'b0) begin
            miscompares++;
            $display("FAIL up_commit: dir=%b armed=%b want 00/0",
                     dir_out, armed);
        end
        vectors++;
        if (dir_change !== 1'b0) begin
            miscompares++;
            $display("FAIL up_chg_t0: dir_change=%b want 0", dir_change);
        end
        edges(1);
        vectors++;
        if (dir_change !== 1'b1) begin
            miscompares++;
            $display("FAIL up_chg_t1: dir_change=%b want 1", dir_change);
        end
        edges(1);
        vectors++;
        if (dir_change !== 1'b0 || dir_out !== 2'b00) begin
            miscompares++;
            $display("FAIL up_chg_t2: chg=%b dir=%b want 0/00",
                     dir_change, dir_out);
        end
    endtask

    task automatic test_opposite;
        do_reset();
        acl_data = X_M8;
        edges(7);
        vectors++;
        if (armed !== 1'b1) begin
            miscompares++;
            $display("FAIL opp_armed: armed=%b want 1", armed);
        end
        game_tick = 1'b1;
        edges(1);
        game_tick = 1'b0;
        vectors++;
        if (dir_out !== 2'b01 || armed !== 1'b0) begin
            miscompares++;
            $display("FAIL opp_reject: dir=%b armed=%b want 01/0",
                     dir_out, armed);
        end
        edges(1);
        vectors++;
        if (dir_change !== 1'b0) begin
            miscompares++;
            $display("FAIL opp_chg: dir_change=%b want 0", dir_change);
        end
    endtask

    // Short glitches are eaten by the stability register, so NONE is held 2 cycles.
    task automatic test_requal;
        do_reset();
        acl_data = Y_P8;
        edges(2);
        acl_data = X_P1;
        edges(2);
        acl_data = Y_P8;
        for (int i = 1; i <= 6; i++) begin
            edges(1);
            vectors++;
            if (armed !== 1'b0) begin
                miscompares++;
                $display("FAIL requal_early: cycle %0d armed=%b want 0",
                         i, armed);
            end
        end
        edges(1);
        vectors++;
        if (armed !== 1'b1) begin
            miscompares++;
            $display("FAIL requal_armed: armed=%b want 1", armed);
        end
    endtask

    task automatic test_hysteresis;
        do_reset();
        acl_data = Y_P4;
        edges(3);
        acl_data = Y_P3;
        edges(3);
        vectors++;
        if (armed !== 1'b0) begin
            miscompares++;
            $display("FAIL hyst_early: armed=%b want 0", armed);
        end
        edges(1);
        vectors++;
        if (armed !== 1'b1) begin
            miscompares++;
            $display("FAIL hyst_armed: armed=%b want 1", armed);
        end
        edges(3);
        vectors++;
        if (armed !== 1'b1) begin
            miscompares++;
            $display("FAIL hyst_hold: armed=%b want 1", armed);
        end
        do_reset();
        acl_data = Y_P3;
        edges(12);
        vectors++;
        if (armed !== 1'b0 || dir_out !== 2'b01) begin
            miscompares++;
            $display("FAIL hyst_idle: armed=%b dir=%b want 0/01",
                     armed, dir_out);
        end
    endtask

    task automatic test_tie;
        do_reset();
        acl_data = TIE_M16;
        edges(7);
        vectors++;
        if (armed !== 1'b1) begin
            miscompares++;
            $display("FAIL tie_armed: armed=%b want 1", armed);
        end
        game_tick = 1'b1;
        edges(1);
        game_tick = 1'b0;
        vectors++;
        if (dir_out !== 2'b01 || armed !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_reject: dir=%b armed=%b want 01/0",
                     dir_out, armed);
        end
        edges(1);
        vectors++;
        if (dir_change !== 1'b0) begin
            miscompares++;
            $display("FAIL tie_chg: dir_change=%b want 0", dir_change);
        end
    endtask

    task automatic test_async_reset;
        do_reset();
        acl_data = Y_P8;
        edges(7);
        vectors++;
        if (armed !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_pre: armed=%b want 1", armed);
        end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (armed !== 1'b0 || dir_out !== 2'b01) begin
            miscompares++;
            $display("FAIL arst_clear: armed=%b dir=%b want 0/01",
                     armed, dir_out);
        end
        @(negedge clk);
        rst = 1'b0;
        edges(6);
        vectors++;
        if (armed !== 1'b0) begin
            miscompares++;
            $display("FAIL arst_requal_early: armed=%b want 0", armed);
        end
        edges(1);
        vectors++;
        if (armed !== 1'b1) begin
            miscompares++;
            $display("FAIL arst_requal: armed=%b want 1", armed);
        end
    endtask

    initial begin
        test_reset();
        test_commit_up();
        test_opposite();
        test_requal();
        test_hysteresis();
        test_tie();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
